vga_bin2bcd: RTL and testbench
==============================

Name: vga_bin2bcd

Overview:
- Upstream stage of the VGA digit display path.
- Converts the 32-bit value to show into packed decimal (BCD) with a leading-zero blank mask, so the pixel renderer draws decimal digits instead of hex nibbles.
- Conversion is sequential (shift-add-3, one bit per cycle) and is started only on the frame-start pulse from the sync controller, so displayed digits change only between frames and never tear.
- Runs in the 25 MHz VGA pixel clock domain.

Parameters:
- DATA_W, 32, width of the binary input; sets the conversion length in cycles.
- DIGITS, 10, number of BCD digits produced; must satisfy 10^DIGITS > 2^DATA_W.

Ports:
- vga_clk  input  1  pixel clock; all state updates on the rising edge.
- rst  input  1  reset: asynchronous, active-low (0 = reset).
- digit  input  DATA_W  binary value to display; sampled only at conversion start.
- frame_start  input  1  one-cycle pulse from the sync controller at the start of vertical blanking.
- bcd_out  output  4*DIGITS  packed BCD; nibble i is 10^i (nibble 0 = LSD).
- blank_mask  output  DIGITS  bit i = 1 means digit i is a leading zero and must not be drawn.
- sign  output  1  1 means the value is negative (optional feature only).
- update  output  1  one-cycle pulse when bcd_out, blank_mask and sign take new values.
- busy  output  1  conversion in progress.

Behaviour:
- Reset values:
  - bcd_out = 0.
  - blank_mask = all ones except bit0 (0x3FE at the default size), so a single "0" is shown.
  - sign = 0, update = 0, busy = 0.
  - State = IDLE; internal shift and scratch registers cleared.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - On an edge where frame_start = 1: capture digit into the binary shift register, clear the BCD scratch register, load the bit counter with DATA_W, set busy = 1, go to SHIFT.
- SHIFT, one input bit per edge:
  - First, add 3 to every scratch nibble whose value is >= 5.
  - Then shift {scratch, bin} left by one, so the MSB of bin enters scratch bit 0.
  - Decrement the counter.
  - After DATA_W edges, go to DONE.
- DONE, one edge:
  - Register scratch into bcd_out.
  - Compute blank_mask. Bit i = 1 iff nibbles DIGITS-1 down to i are all zero and i != 0; bit0 is always 0.
  - Set update = 1 for exactly this one cycle and busy = 0; return to IDLE.
- Latency:
  - frame_start sampled at edge k, so outputs and the update pulse appear after edge k+DATA_W+1 (33 cycles at the default size).
  - busy is high from after edge k until the update cycle.
- Outputs hold their last value between updates. The downstream renderer may read them at any time.
- frame_start while busy, or in the DONE cycle: ignored, with no queuing. The next conversion waits for the next frame_start.
- digit changing during a conversion: no effect; the captured value is used.
- Simultaneous rst low and frame_start: reset wins.
- Reset mid-conversion: aborts immediately, all outputs return to reset values, no update pulse.
- Arithmetic:
  - Add-3 is per nibble, with no carry between nibbles.
  - The scratch register is 4*DIGITS bits; no overflow is possible when the DIGITS constraint holds.

Optional Feature:
- Macro: VGA_BCD_SIGNED_EN.
- With the macro defined:
  - digit is two's complement. At capture, its MSB is stored and the magnitude (negated when MSB = 1) is loaded into the shift register.
  - sign is registered in DONE together with bcd_out.
  - 0x80000000 converts to magnitude 2147483648.
- Without the macro:
  - digit is unsigned.
  - sign is tied to 0.
  - No negation logic is present.

Test Plan:
- Reset, then frame_start with digit = 0 -> update after 33 cycles; bcd_out = 0x0000000000, blank_mask = 0x3FE.
- digit = 0xFFFFFFFF, frame_start -> bcd_out = 0x4294967295, blank_mask = 0x000, busy high for exactly 33 cycles.
- digit = 12345 -> bcd_out = 0x0000012345, blank_mask = 0x3E0. Change digit to 99 at cycle 10 of the conversion -> result still 12345.
- Second frame_start at cycle 5 of a busy conversion -> ignored; exactly one update pulse; the next frame_start converts the new digit.
- Pull rst low at cycle 20 of converting 0x12345678 -> outputs return to reset values, no update. After release plus frame_start -> bcd_out = 0x0305419896.
- VGA_BCD_SIGNED_EN: digit = 0x80000000 -> sign = 1, bcd_out = 0x2147483648. digit = 0xFFFFFFFF -> sign = 1, bcd_out = 0x0000000001, blank_mask = 0x3FE.

Source files
------------

// File: rtl/vga_bin2bcd.sv
// rtl/vga_bin2bcd.sv - frame-synchronous binary to BCD converter with leading-zero blank mask
// Optional signed input handling is enabled by defining VGA_BCD_SIGNED_EN.
module vga_bin2bcd #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 10
) (
  input  logic                  vga_clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     digit,
  input  logic                  frame_start,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  sign,
  output logic                  update,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DIGITS-1:0] MASK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] bin;
  logic [DATA_W-1:0] load_val;
  logic [BCD_W-1:0]  scratch;
  logic [BCD_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt;
  logic [DIGITS-1:0] mask_nxt;
  logic              upper_zero;

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-nibble add-3 correction; nibbles never carry into each other.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // A digit is blanked only when it and every more significant digit are zero.
  always_comb begin
    mask_nxt   = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero & (scratch[4*i +: 4] == 4'd0);
      mask_nxt[i] = upper_zero;
    end
  end

`ifdef VGA_BCD_SIGNED_EN
  logic sign_cap;

  assign load_val = digit[DATA_W-1] ? (DATA_W'(0) - digit) : digit;

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      sign_cap <= 1'b0;
      sign     <= 1'b0;
    end else begin
      if (state == IDLE && frame_start) sign_cap <= digit[DATA_W-1];
      if (state == DONE)                sign     <= sign_cap;
    end
  end
`else
  assign load_val = digit;
  assign sign     = 1'b0;
`endif

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      bin        <= '0;
      scratch    <= '0;
      cnt        <= '0;
      bcd_out    <= '0;
      blank_mask <= MASK_RST;
      update     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            bin     <= load_val;
            scratch <= '0;
            cnt     <= CNT_W'(DATA_W);
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= {adj[BCD_W-2:0], bin[DATA_W-1]};
          bin     <= {bin[DATA_W-2:0], 1'b0};
          cnt     <= cnt - CNT_W'(1);
        end
        DONE: begin
          bcd_out    <= scratch;
          blank_mask <= mask_nxt;
          update     <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_bin2bcd.sv
// tb/tb_vga_bin2bcd.sv - self-checking bench for vga_bin2bcd against a decimal arithmetic model
module tb_vga_bin2bcd;
  localparam int DATA_W = 32;
  localparam int DIGITS = 10;
  localparam int LAT    = DATA_W + 1;

  logic                vga_clk = 1'b0;
  logic                rst = 1'b0;
  logic [DATA_W-1:0]   digit = '0;
  logic                frame_start = 1'b0;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   blank_mask;
  logic                sign;
  logic                update;
  logic                busy;

  vga_bin2bcd #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .vga_clk(vga_clk), .rst(rst), .digit(digit), .frame_start(frame_start),
    .bcd_out(bcd_out), .blank_mask(blank_mask), .sign(sign), .update(update), .busy(busy)
  );

  always #20 vga_clk = ~vga_clk;

  int n_pass = 0;
  int n_total = 0;
  int busy_cnt = 0;
  int upd_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Decimal digits by repeated division, independent of shift-add-3.
  function automatic logic [4*DIGITS-1:0] to_bcd(input longint unsigned v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] to_mask(input longint unsigned v);
    logic [DIGITS-1:0] m;
    int nd;
    nd = 1;
    v = v / 10;
    while (v > 0) begin
      nd++;
      v = v / 10;
    end
    for (int i = 0; i < DIGITS; i++) m[i] = (i >= nd);
    return m;
  endfunction

  // Reference: a conversion started at edge k publishes its result at edge k+LAT.
  logic [4*DIGITS-1:0] m_bcd = '0;
  logic [DIGITS-1:0]   m_mask = {{(DIGITS-1){1'b1}}, 1'b0};
  logic                m_sign = 1'b0;
  logic                m_update = 1'b0;
  logic                m_busy = 1'b0;
  int                  m_left = 0;
  longint unsigned     m_mag = 0;
  logic                m_neg = 1'b0;

  always @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      m_bcd = '0; m_mask = {{(DIGITS-1){1'b1}}, 1'b0}; m_sign = 1'b0;
      m_update = 1'b0; m_busy = 1'b0; m_left = 0;
    end else begin
      m_update = 1'b0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_bcd = to_bcd(m_mag); m_mask = to_mask(m_mag); m_sign = m_neg; m_update = 1'b1;
        end
      end else if (frame_start) begin
`ifdef VGA_BCD_SIGNED_EN
        m_neg = digit[DATA_W-1];
        m_mag = m_neg ? (64'h1_0000_0000 - longint'(digit)) : longint'(digit);
`else
        m_neg = 1'b0;
        m_mag = longint'(digit);
`endif
        m_left = LAT;
      end
      m_busy = (m_left != 0);
    end
  end

  always @(posedge vga_clk) begin
    #2;
    check("cyc_bcd_out", 64'(bcd_out), 64'(m_bcd));
    check("cyc_blank_mask", 64'(blank_mask), 64'(m_mask));
    check("cyc_sign", 64'(sign), 64'(m_sign));
    check("cyc_busy", 64'(busy), 64'(m_busy));
    check("cyc_update", 64'(update), 64'(m_update));
    if (busy) busy_cnt++;
    if (update) upd_cnt++;
  end

  task automatic start(input logic [DATA_W-1:0] v);
    @(negedge vga_clk);
    digit = v;
    frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_update(output int cyc);
    cyc = 0;
    do begin
      @(posedge vga_clk);
      #2;
      cyc++;
    end while (!update && cyc < 100);
    if (!update) begin
      n_total++;
      $display("FAIL update_timeout: no update within %0d cycles", cyc);
    end
  endtask

  int cyc;

  initial begin
    repeat (3) @(negedge vga_clk);
    check("rst_bcd_out", 64'(bcd_out), 64'h0);
    check("rst_blank_mask", 64'(blank_mask), 64'h3FE);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_update", 64'(update), 64'h0);
    check("rst_sign", 64'(sign), 64'h0);
    check("model_bcd_12345", 64'(to_bcd(12345)), 64'h12345);
    check("model_mask_12345", 64'(to_mask(12345)), 64'h3E0);
    check("model_bcd_max", 64'(to_bcd(64'hFFFF_FFFF)), 64'h42_9496_7295);
    check("model_mask_0", 64'(to_mask(0)), 64'h3FE);
    @(negedge vga_clk);
    rst = 1'b1;

    busy_cnt = 0;
    start(32'd0);
    wait_update(cyc);
    check("zero_latency", 64'(cyc), 64'd33);
    check("zero_bcd", 64'(bcd_out), 64'h0);
    check("zero_mask", 64'(blank_mask), 64'h3FE);
    check("zero_busy_cycles", 64'(busy_cnt), 64'd33);

    busy_cnt = 0;
    start(32'hFFFF_FFFF);
    wait_update(cyc);
    check("max_latency", 64'(cyc), 64'd33);
    check("max_busy_cycles", 64'(busy_cnt), 64'd33);
`ifdef VGA_BCD_SIGNED_EN
    check("neg1_bcd", 64'(bcd_out), 64'h1);
    check("neg1_mask", 64'(blank_mask), 64'h3FE);
    check("neg1_sign", 64'(sign), 64'h1);
`else
    check("max_bcd", 64'(bcd_out), 64'h42_9496_7295);
    check("max_mask", 64'(blank_mask), 64'h000);
    check("max_sign", 64'(sign), 64'h0);
`endif

    start(32'd12345);
    repeat (9) @(negedge vga_clk);
    digit = 32'd99;
    wait_update(cyc);
    check("hold_bcd", 64'(bcd_out), 64'h12345);
    check("hold_mask", 64'(blank_mask), 64'h3E0);

    upd_cnt = 0;
    start(32'd777);
    repeat (4) @(negedge vga_clk);
    digit = 32'd555;
    frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
    wait_update(cyc);
    check("ignore_bcd", 64'(bcd_out), 64'h777);
    repeat (40) @(negedge vga_clk);
    check("ignore_one_update", 64'(upd_cnt), 64'd1);
    start(32'd555);
    wait_update(cyc);
    check("next_bcd", 64'(bcd_out), 64'h555);

    upd_cnt = 0;
    start(32'h1234_5678);
    repeat (19) @(negedge vga_clk);
    rst = 1'b0;
    frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
    repeat (2) @(negedge vga_clk);
    check("abort_bcd", 64'(bcd_out), 64'h0);
    check("abort_mask", 64'(blank_mask), 64'h3FE);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_no_update", 64'(upd_cnt), 64'd0);
    rst = 1'b1;
    start(32'h1234_5678);
    wait_update(cyc);
    check("after_abort_bcd", 64'(bcd_out), 64'h03_0541_9896);

    start(32'h8000_0000);
    wait_update(cyc);
    check("min_bcd", 64'(bcd_out), 64'h21_4748_3648);
`ifdef VGA_BCD_SIGNED_EN
    check("min_sign", 64'(sign), 64'h1);
`else
    check("min_sign", 64'(sign), 64'h0);
`endif

    for (int n = 0; n < 2000; n++) begin
      @(negedge vga_clk);
      digit = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 999)) : 32'($urandom);
      frame_start = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 399) != 0);
    end
    @(negedge vga_clk);
    rst = 1'b1;
    frame_start = 1'b0;
    repeat (40) @(negedge vga_clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
